// File: rtl/level_pkg.sv
// rtl/level_pkg.sv - shared types and constants for the level column streamer
package level_pkg;
    typedef logic [2:0]  blk_id_t;
    typedef logic [29:0] col_t;

    localparam blk_id_t BLK_EMPTY  = 3'd0;
    localparam blk_id_t BLK_BRICK  = 3'd1;
    localparam blk_id_t BLK_QBLOCK = 3'd3;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int COLS_VISIBLE = 10;
endpackage

// File: rtl/level_word_decode.sv
// rtl/level_word_decode.sv - splits a level ROM word into column and repeat field (LEVEL_RLE_EN)
module level_word_decode
    import level_pkg::*;
(
    input  logic [31:0] rom_data,
    output col_t        col,
    output logic [1:0]  rep
);
    assign col = rom_data[29:0];

`ifdef LEVEL_RLE_EN
    // Repeat field holds count minus one, so a word emits 1 to 4 columns.
    assign rep = rom_data[31:30];
`else
    logic unused_rep_bits;
    assign unused_rep_bits = ^rom_data[31:30];
    assign rep = 2'b00;
`endif
endmodule

// File: rtl/level_column_streamer.sv
// rtl/level_column_streamer.sv - walks the level ROM and shifts columns into the scroll store (LEVEL_RLE_EN)
module level_column_streamer
    import level_pkg::*;
#(
    parameter int COLS_VISIBLE = level_pkg::COLS_VISIBLE,
    parameter int LEVEL_LEN    = 256,
    parameter int ADDR_W       = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              scroll_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output col_t              new_block_id,
    output logic              Shift,
    output logic [7:0]        current_col,
    output logic              ready,
    output logic              level_end
);
    localparam int PC_W = $clog2(COLS_VISIBLE + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEVEL_LEN - 1);

    state_t          state;
    col_t            buf_col;
    col_t            dec_col;
    logic [1:0]      buf_rep;
    logic [1:0]      dec_rep;
    logic [PC_W-1:0] preload_cnt;
    logic            pending;
    logic            preloading;
    logic            fire;

    level_word_decode u_decode (
        .rom_data (rom_data),
        .col      (dec_col),
        .rep      (dec_rep)
    );

    // Preload ignores frame gating so the visible window fills as fast as the ROM allows.
    assign preloading = preload_cnt < PC_W'(COLS_VISIBLE);
    assign fire       = (state == ST_HOLD) && (preloading || (pending && frame_start));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= ST_FETCH;
            rom_addr     <= '0;
            buf_col      <= '0;
            buf_rep      <= '0;
            preload_cnt  <= '0;
            pending      <= 1'b0;
            new_block_id <= '0;
            Shift        <= 1'b0;
            current_col  <= '0;
            ready        <= 1'b0;
            level_end    <= 1'b0;
        end else begin
            Shift   <= 1'b0;
            pending <= (pending & ~fire) | (scroll_req & ready & (state != ST_DONE));
            case (state)
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    buf_col <= dec_col;
                    buf_rep <= dec_rep;
                    state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (fire) begin
                        Shift        <= 1'b1;
                        new_block_id <= buf_col;
                        current_col  <= current_col + 8'd1;
                        if (preloading) begin
                            preload_cnt <= preload_cnt + PC_W'(1);
                            if (preload_cnt == PC_W'(COLS_VISIBLE - 1))
                                ready <= 1'b1;
                        end
                        if (buf_rep != 2'b00) begin
                            buf_rep <= buf_rep - 2'b01;
                        end else if (rom_addr == LAST_ADDR) begin
                            state     <= ST_DONE;
                            level_end <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + ADDR_W'(1);
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: state <= ST_DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_level_column_streamer.sv
// tb/tb_level_column_streamer.sv - directed self-checking bench for level_column_streamer (LEVEL_RLE_EN)
module tb_level_column_streamer;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic        scroll_req;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic [29:0] new_block_id;
    logic        Shift;
    logic [7:0]  current_col;
    logic        ready;
    logic        level_end;

    logic [31:0] rom [16];
    int n_checks = 0;
    int n_fail   = 0;
    int exp_pre_col [10];
    int exp_gap [10];
    int next_col;
    int exp_total;
    int gap;

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom[rom_addr[3:0]];

    level_column_streamer #(
        .COLS_VISIBLE (10),
        .LEVEL_LEN    (16),
        .ADDR_W       (8)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_start  (frame_start),
        .scroll_req   (scroll_req),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .new_block_id (new_block_id),
        .Shift        (Shift),
        .current_col  (current_col),
        .ready        (ready),
        .level_end    (level_end)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic wait_shift(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!Shift && cycles < 20);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, " rom_addr"}, 32'(rom_addr), 0);
        check_eq({tag, " new_block_id"}, 32'(new_block_id), 0);
        check_eq({tag, " Shift"}, 32'(Shift), 0);
        check_eq({tag, " current_col"}, 32'(current_col), 0);
        check_eq({tag, " ready"}, 32'(ready), 0);
        check_eq({tag, " level_end"}, 32'(level_end), 0);
    endtask

    // Idle long enough to reach HOLD, then one frame_start pulse.
    task automatic frame(input string tag, input logic exp_shift);
        int idle_shifts;
        idle_shifts = 0;
        repeat (4) begin
            tick();
            if (Shift) idle_shifts++;
        end
        check_eq({tag, " idle shifts"}, 32'(idle_shifts), 0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_eq({tag, " Shift"}, 32'(Shift), 32'(exp_shift));
        if (exp_shift) begin
            check_eq({tag, " col"}, 32'(new_block_id), 32'(next_col));
            next_col++;
        end
    endtask

    initial begin
        Reset = 1'b1;
        frame_start = 1'b0;
        scroll_req = 1'b0;
        for (int k = 0; k < 16; k++) rom[k] = {2'b00, 30'(k)};
        rom[0][31:30] = 2'b11;
`ifdef LEVEL_RLE_EN
        exp_pre_col = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6};
        exp_gap     = '{3, 1, 1, 1, 3, 3, 3, 3, 3, 3};
        next_col    = 7;
        exp_total   = 19;
`else
        exp_pre_col = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        exp_gap     = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        next_col    = 10;
        exp_total   = 16;
`endif
        repeat (2) tick();
        check_zero_outputs("reset");

        // Preload with scroll_req held high; it must not arm a request.
        Reset = 1'b0;
        scroll_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_shift(gap);
            check_eq($sformatf("preload gap %0d", i), 32'(gap), 32'(exp_gap[i]));
            check_eq($sformatf("preload col %0d", i), 32'(new_block_id), 32'(exp_pre_col[i]));
            if (i == 8) check_eq("ready before 10th", 32'(ready), 0);
        end
        scroll_req = 1'b0;
        check_eq("ready after preload", 32'(ready), 1);
        check_eq("current_col after preload", 32'(current_col), 10);
        check_eq("level_end after preload", 32'(level_end), 0);
        frame("preload req ignored", 1'b0);

        scroll_req = 1'b1;
        for (int i = 0; i < 3; i++) frame($sformatf("run %0d", i), 1'b1);

        // Pending request survives a frame_start that lands in FETCH.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_eq("fetch frame Shift", 32'(Shift), 0);
        frame("after fetch frame", 1'b1);

        scroll_req = 1'b0;
        frame("last armed", 1'b1);
        frame("no request", 1'b0);
        scroll_req = 1'b1;
        tick();
        scroll_req = 1'b0;
        frame("one-cycle request", 1'b1);

        scroll_req = 1'b1;
        for (int i = 0; i < 20 && next_col <= 15; i++) begin
            check_eq($sformatf("level_end before col %0d", next_col), 32'(level_end), 0);
            frame($sformatf("run col %0d", next_col), 1'b1);
        end
        check_eq("level_end", 32'(level_end), 1);
        check_eq("rom_addr at end", 32'(rom_addr), 15);

        frame("done 0", 1'b0);
        frame("done 1", 1'b0);
        check_eq("done current_col", 32'(current_col), 32'(exp_total));
        check_eq("done new_block_id", 32'(new_block_id), 15);
        check_eq("done level_end", 32'(level_end), 1);

        // Reset while the 5th preload shift is on the output.
        scroll_req = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) wait_shift(gap);
        check_eq("mid preload col", 32'(new_block_id), 32'(exp_pre_col[4]));
        Reset = 1'b1;
        tick();
        check_zero_outputs("mid reset");
        Reset = 1'b0;
        wait_shift(gap);
        check_eq("restart gap", 32'(gap), 3);
        check_eq("restart col", 32'(new_block_id), 0);
        check_eq("restart current_col", 32'(current_col), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/level_column_streamer.md
# level_column_streamer

Feeds level geometry to the scrolling block-column store. Walks a synchronous level ROM one column word at a time and decodes each word into a 30-bit column (10 rows × 3-bit block ID, row 0 in bits [2:0]). Presents the column on `new_block_id` with a one-cycle `Shift` pulse. Issues 10 back-to-back shifts after reset to fill the visible window, then one shift per frame on scroll request.

## Interface
Parameters:
- `COLS_VISIBLE`, 10: columns shifted in during preload.
- `LEVEL_LEN`, 256: number of ROM words in the level.
- `ADDR_W`, 8: ROM address width; LEVEL_LEN ≤ 2^ADDR_W.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high.
- `frame_start` in 1: one-cycle pulse per frame (vsync edge).
- `scroll_req` in 1: level from Mario logic; request one column of scroll.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_data` in 32: ROM word, valid 1 cycle after `rom_addr` changes; [29:0] column, [31:30] repeat field.
- `new_block_id` out 30: current column; held between shifts.
- `Shift` out 1: one-cycle pulse; `new_block_id` valid in the same cycle.
- `current_col` out 8: count of shifts issued since reset, wraps 255→0.
- `ready` out 1: preload complete.
- `level_end` out 1: last ROM word fully consumed.

## Operation
- Reset values: `rom_addr`=0, `new_block_id`=0, `Shift`=0, `current_col`=0, `ready`=0, `level_end`=0. Internal: `preload_cnt`=0, `pending`=0, `buf_rep`=0, state=FETCH.
- FSM states and transitions:
  - FETCH: `rom_addr` is stable; go to WAIT.
  - WAIT: capture `buf_col`=`rom_data[29:0]` and `buf_rep`; go to HOLD.
  - HOLD: wait for a fire condition (below).
  - DONE: terminal; leave only on Reset.
- Fire condition in HOLD:
  - During preload (`preload_cnt`<COLS_VISIBLE): fire immediately, no frame gating.
  - During run mode: fire when `pending` && `frame_start`.
- On fire, registered at the next edge:
  - `Shift`=1, `new_block_id`=`buf_col`, `current_col`++.
  - `preload_cnt`++, saturating at COLS_VISIBLE.
  - Clear `pending`.
- Next step after fire:
  - If `buf_rep`≠0: decrement `buf_rep` and stay in HOLD.
  - Else if `rom_addr`==LEVEL_LEN-1: go to DONE and set `level_end`=1.
  - Else: `rom_addr`++ and go to FETCH.
- `ready` rises in the cycle `preload_cnt` reaches COLS_VISIBLE and stays high until Reset.
- `pending` update: `pending` ← (`pending` & ~fire) | (`scroll_req` & `ready` & state≠DONE).
  - `scroll_req` high in the fire cycle re-arms `pending` for the next frame.
- Limits and boundaries:
  - Run mode allows at most one shift per `frame_start`.
  - `frame_start` while in FETCH/WAIT does not fire; `pending` is kept for the next frame.
  - `scroll_req` during preload is ignored.
  - In DONE: `Shift` stays 0, `scroll_req` is ignored, `new_block_id` holds the last column.
  - Reset mid-operation: full return to reset values at that edge; `Shift`=0 that cycle.

## Timing
- Fetch cost: FETCH→WAIT→HOLD is 2 cycles.
  - First fire occurs on the 3rd edge after Reset deasserts.
  - The `Shift` pulse is seen in the following cycle.
- Preload throughput:
  - Distinct columns: one `Shift` every 3 cycles.
  - Repeated columns: one `Shift` per cycle.
- Run-mode latency: `Shift` is high the cycle after the `frame_start` that satisfies fire.
- `Shift` is never high in two consecutive cycles except for preload repeats.

## Configuration
- `LEVEL_RLE_EN` defined:
  - `rom_data[31:30]` is the repeat count minus one.
  - Each word emits 1–4 identical columns.
- `LEVEL_RLE_EN` undefined:
  - Bits [31:30] are ignored and `buf_rep` is tied to 0.
  - Each word emits exactly one column.

## Structure
- Shared package `level_pkg` holds:
  - `blk_id_t` (3-bit) and `col_t` (30-bit) typedefs.
  - Block-ID constants: EMPTY=0, BRICK=1, QBLOCK=3.
  - The state enum.
  - COLS_VISIBLE.
- One sub-module, `level_word_decode`: combinational split of `rom_data` into `col_t` plus repeat field, honoring `LEVEL_RLE_EN`.

## Test plan
- Reset, LEVEL_LEN=16, words k→col k, RLE off → 10 `Shift` pulses 3 cycles apart with `new_block_id`=0..9; `ready`=1 after 10th; `current_col`=10.
- After preload, hold `scroll_req`=1 and pulse `frame_start` 3 times → exactly 3 shifts (cols 10,11,12), each one cycle after a `frame_start`.
- RLE on, word 0 repeat field=3 → preload emits 4 consecutive-cycle shifts of col 0, then col 1 three cycles later.
- Request pending while in FETCH at `frame_start` → no shift; shift occurs on the next `frame_start`.
- Consume word 15 of 16 → `level_end`=1; further `scroll_req`/`frame_start` produce no `Shift`; `current_col` frozen.
- Reset asserted during preload at shift 5 → all outputs 0 next cycle; preload restarts from word 0.
